// File: rtl/osc_meas_ctrl.sv
// osc_meas_ctrl: enables the ring oscillator, lets it settle, then counts
// its synchronized rising edges over a programmable window of clk cycles.
module osc_meas_ctrl #(
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic             osc_out,
    output logic             osc_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_e;

    state_e           state_q;
    logic [2:0]       sync_q;
    logic [WIN_W-1:0] win_q;
    logic [TMR_W-1:0] tmr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             osc_en_q, busy_q, done_q, ovf_q;
    logic [CNT_W-1:0] count_q;
    logic             edge_det;
    logic             win_last;

    // Aliases above clk/2 are not detected; only s2 rising over s3 counts.
    assign edge_det = sync_q[1] & ~sync_q[2];
    assign win_last = (tmr_q == TMR_W'(win_q) - TMR_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (edge_det) begin
            if (&cnt_q) sat_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            win_q    <= '0;
            tmr_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            osc_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], osc_out};
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q  <= SETTLE;
                        osc_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        win_q    <= win_len;
                        tmr_q    <= '0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q  <= IDLE;
                        osc_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (tmr_q == SET_LAST) begin
                        tmr_q <= '0;
                        cnt_q <= '0;
                        sat_q <= 1'b0;
                        if (win_q == '0) begin
                            state_q  <= DONE;
                            osc_en_q <= 1'b0;
                            done_q   <= 1'b1;
                            count_q  <= '0;
                            ovf_q    <= 1'b0;
                        end else begin
                            state_q <= MEASURE;
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                MEASURE: begin
                    if (abort) begin
                        state_q  <= IDLE;
                        osc_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        sat_q <= sat_d;
                        tmr_q <= tmr_q + TMR_W'(1);
                        if (win_last) begin
                            state_q  <= DONE;
                            osc_en_q <= 1'b0;
                            done_q   <= 1'b1;
                            count_q  <= cnt_d;
                            ovf_q    <= sat_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign osc_en = osc_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign count  = count_q;
    assign ovf    = ovf_q;
endmodule
